piso_tx_arbiter: RTL and testbench
==================================

PISO_TX_ARBITER -- requirements
Module: piso_tx_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: serialized word width, minimum 2.
REQ-002 Parameter GAP_CYCLES, default 1: idle cycles inserted after each frame, range 0..15.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req0_valid  in  1  requester 0 has a word pending.
REQ-006 req0_data  in  DATA_W  requester 0 word.
REQ-007 req0_ready  out  1  requester 0 word accepted this cycle.
REQ-008 req1_valid, req1_data, req1_ready: same as REQ-005..007, for requester 1.
REQ-009 ser_out  out  1  serial bit, MSB first.
REQ-010 ser_valid  out  1  ser_out carries a frame bit this cycle.
REQ-011 ser_last  out  1  high only during the final bit of a frame.
REQ-012 grant_id  out  1  owner of the current or last frame (0 or 1).
REQ-013 busy  out  1  high in SHIFT and GAP states.

Function
REQ-014 The FSM SHALL have exactly three states:
- IDLE
- SHIFT
- GAP
REQ-015 In IDLE, the arbiter SHALL choose combinationally among the valid requesters.
- Only one valid: that requester wins.
- Both valid: the requester not granted last wins (round-robin).
REQ-016 reqN_ready SHALL be combinational: high only in IDLE, only when reqN_valid is high and N wins; at most one ready is high per cycle.
REQ-017 On a clk edge with valid&&ready, the block SHALL:
- load reqN_data into the shift register;
- set grant_id=N and the round-robin pointer to N;
- load the bit counter with DATA_W-1;
- move to SHIFT.
REQ-018 Latency: for a word accepted at edge k, bits SHALL appear in the DATA_W cycles following edge k, MSB first, with ser_valid=1 throughout.
REQ-019 In SHIFT, each edge SHALL shift left one bit and decrement the counter; ser_last=1 when the counter is 0.
REQ-020 After the last bit, next state SHALL be:
- GAP, for GAP_CYCLES cycles, if GAP_CYCLES>0;
- otherwise IDLE.
REQ-021 In GAP and SHIFT, both readies SHALL be 0 and new requests SHALL be ignored (held off, not dropped).
REQ-022 A requester SHALL hold valid and data stable until it sees ready; the block does not latch unaccepted data.
REQ-023 Minimum spacing from one frame start to the next SHALL be DATA_W+GAP_CYCLES+1 cycles.
REQ-024 ser_out SHALL be 0 whenever ser_valid=0.

Reset
REQ-025 Asserting reset SHALL immediately (asynchronously) force:
- state IDLE;
- shift register, counter and GAP counter to 0;
- ser_out, ser_valid, ser_last, busy and grant_id to 0.
REQ-026 On reset, the round-robin pointer SHALL be set so that requester 0 wins the first contention.
REQ-027 Reset mid-frame SHALL abort the frame with no further bits; the aborted word is not replayed.

Structure
REQ-028 Package piso_pkg SHALL hold:
- the state enum (IDLE, SHIFT, GAP);
- the DATA_W default constant.
REQ-029 The shift register SHALL be the sub-module piso_shift, with ports:
- clk, reset;
- load, shift_en, din[DATA_W];
- msb.

Verification
REQ-030 Reset, no requests -> all outputs 0, both readies 0, busy 0.
REQ-031 req0 only, 8'hD5 -> req0_ready for 1 cycle, then:
- ser_out 1,1,0,1,0,1,0,1 on 8 consecutive cycles;
- ser_last on the 8th; grant_id=0; busy 1 for 9 cycles (8 SHIFT + 1 GAP).
REQ-032 req0=8'h9A and req1=8'h3C held valid together for 40 cycles -> frames alternate 9A,3C,9A,3C, starting with req0, each 10 cycles apart.
REQ-033 req1 only, after reset -> req1 granted at once; grant_id=1; 8'hA5 serialized 1,0,1,0,0,1,0,1.
REQ-034 Reset asserted during the 4th bit of 8'hFF -> ser_valid falls in the same cycle. After release, with both valid, req0 wins.
REQ-035 GAP_CYCLES=0, back-to-back req0 words -> exactly one non-valid cycle (IDLE) between the two frames.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the two-requester serializing arbiter.
package piso_pkg;

  localparam int unsigned DataWDefault = 8;
  localparam int unsigned GapW         = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

endpackage

// File: rtl/piso_tx_arbiter_if.sv
// Requester handshakes and serial output bundle of the arbiter.
interface piso_tx_arbiter_if #(
  parameter int unsigned DATA_W = piso_pkg::DataWDefault
) ();

  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_last;
  logic              grant_id;
  logic              busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, ser_out, ser_valid, ser_last, grant_id, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, ser_out, ser_valid, ser_last, grant_id, busy
  );

endinterface

// File: rtl/piso_shift.sv
// Parallel-load, left-shifting register exposing its MSB as the serial bit.
module piso_shift #(
  parameter int unsigned DATA_W = piso_pkg::DataWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift_en) begin
      sr_q <= {sr_q[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = sr_q[DATA_W-1];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter between two word requesters feeding one MSB-first serial
// stream, with an optional idle gap after every frame.
module piso_tx_arbiter
  import piso_pkg::*;
#(
  parameter int unsigned DATA_W     = DataWDefault,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  piso_tx_arbiter_if.slave bus
);

  localparam int unsigned    CntW    = $clog2(DATA_W);
  localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              load, shift_en, sel1;
  logic [DATA_W-1:0] din;
  logic              msb;

  piso_shift #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .din      (din),
    .msb      (msb)
  );

  // last_q resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Requester 1 wins when alone, or when both ask and 0 was served last.
  assign sel1 = bus.req1_valid && (!bus.req0_valid || !last_q);
  assign din  = sel1 ? bus.req1_data : bus.req0_data;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    grant_d        = grant_q;
    last_d         = last_q;
    load           = 1'b0;
    shift_en       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.req0_ready = bus.req0_valid && !sel1;
        bus.req1_ready = sel1;
        if (bus.req0_valid || bus.req1_valid) begin
          load    = 1'b1;
          grant_d = sel1;
          last_d  = sel1;
          cnt_d   = CntW'(DATA_W - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        shift_en = 1'b1;
        if (cnt_q == '0) begin
          gap_d   = GapLoad;
          state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.ser_valid = (state_q == StShift);
  assign bus.ser_out   = bus.ser_valid && msb;
  assign bus.ser_last  = bus.ser_valid && (cnt_q == '0);
  assign bus.busy      = (state_q != StIdle);
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter: one instance with a 1-cycle gap, one with none.
module tb_piso_tx_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic use_b2 = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  piso_tx_arbiter_if #(.DATA_W(8)) b1 ();
  piso_tx_arbiter_if #(.DATA_W(8)) b2 ();

  piso_tx_arbiter #(
    .DATA_W     (8),
    .GAP_CYCLES (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  piso_tx_arbiter #(
    .DATA_W     (8),
    .GAP_CYCLES (0)
  ) dut_nogap (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  logic mon_out, mon_valid, mon_last, mon_gid, mon_busy, mon_r0, mon_r1;
  assign mon_out   = use_b2 ? b2.ser_out    : b1.ser_out;
  assign mon_valid = use_b2 ? b2.ser_valid  : b1.ser_valid;
  assign mon_last  = use_b2 ? b2.ser_last   : b1.ser_last;
  assign mon_gid   = use_b2 ? b2.grant_id   : b1.grant_id;
  assign mon_busy  = use_b2 ? b2.busy       : b1.busy;
  assign mon_r0    = use_b2 ? b2.req0_ready : b1.req0_ready;
  assign mon_r1    = use_b2 ? b2.req1_ready : b1.req1_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Called on the negedge where the MSB is visible; returns on the negedge of the last bit.
  task automatic expect_frame(input string tag, input logic [7:0] word, input logic gid);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, "_bit"}, 32'(mon_out), 32'(word[7-i]));
      check({tag, "_valid"}, 32'(mon_valid), 32'd1);
      check({tag, "_last"}, 32'(mon_last), (i == 7) ? 32'd1 : 32'd0);
      check({tag, "_gid"}, 32'(mon_gid), 32'(gid));
      check({tag, "_busy"}, 32'(mon_busy), 32'd1);
      check({tag, "_rdy"}, 32'(mon_r0 | mon_r1), 32'd0);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_out"}, 32'(mon_out), 32'd0);
    check({tag, "_valid"}, 32'(mon_valid), 32'd0);
    check({tag, "_last"}, 32'(mon_last), 32'd0);
  endtask

  logic [7:0] acc;
  int         n_frames;
  int         prev_start;
  logic       prev_valid;
  int         waited;

  initial begin
    b1.req0_valid = 1'b0; b1.req0_data = '0; b1.req1_valid = 1'b0; b1.req1_data = '0;
    b2.req0_valid = 1'b0; b2.req0_data = '0; b2.req1_valid = 1'b0; b2.req1_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_quiet("rst");
    check("rst_gid", 32'(mon_gid), 32'd0);
    check("rst_busy", 32'(mon_busy), 32'd0);
    check("rst_rdy", 32'({mon_r0, mon_r1}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("idle");
    check("idle_busy", 32'(mon_busy), 32'd0);
    check("idle_rdy", 32'({mon_r0, mon_r1}), 32'd0);

    // req0 alone: D5, then a GAP cycle, then req1 held off during GAP
    b1.req0_valid = 1'b1; b1.req0_data = 8'hD5;
    #1;
    check("d5_rdy0", 32'(mon_r0), 32'd1);
    check("d5_rdy1", 32'(mon_r1), 32'd0);
    @(negedge clk);
    b1.req0_valid = 1'b0;
    expect_frame("d5", 8'hD5, 1'b0);
    @(negedge clk);
    check_quiet("d5_gap");
    check("d5_gap_busy", 32'(mon_busy), 32'd1);
    b1.req1_valid = 1'b1; b1.req1_data = 8'h3C;
    #1;
    check("gap_holdoff", 32'({mon_r0, mon_r1}), 32'd0);
    @(negedge clk);
    check("after_gap_busy", 32'(mon_busy), 32'd0);
    check("after_gap_rdy1", 32'(mon_r1), 32'd1);
    @(negedge clk);
    b1.req1_valid = 1'b0;
    expect_frame("held", 8'h3C, 1'b1);

    // Both valid for 40 cycles after reset: 9A,3C,9A,3C every 10 cycles
    pulse_reset();
    b1.req0_valid = 1'b1; b1.req0_data = 8'h9A;
    b1.req1_valid = 1'b1; b1.req1_data = 8'h3C;
    n_frames = 0; prev_start = -10; prev_valid = 1'b0; acc = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mon_valid && !prev_valid) begin
        check("rr_spacing", 32'(c - prev_start), 32'd10);
        prev_start = c;
      end
      if (mon_valid) acc = {acc[6:0], mon_out};
      if (mon_last) begin
        check("rr_word", 32'(acc), (n_frames % 2 == 0) ? 32'h9A : 32'h3C);
        check("rr_gid", 32'(mon_gid), 32'(n_frames % 2));
        n_frames++;
      end
      prev_valid = mon_valid;
    end
    check("rr_frames", 32'(n_frames), 32'd4);
    b1.req0_valid = 1'b0; b1.req1_valid = 1'b0;
    waited = 0;
    while (mon_busy && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check("rr_drain", 32'(mon_busy), 32'd0);

    // req1 alone after reset
    pulse_reset();
    b1.req1_valid = 1'b1; b1.req1_data = 8'hA5;
    #1;
    check("a5_rdy1", 32'(mon_r1), 32'd1);
    check("a5_rdy0", 32'(mon_r0), 32'd0);
    @(negedge clk);
    b1.req1_valid = 1'b0;
    expect_frame("a5", 8'hA5, 1'b1);

    // Reset during 4th bit of FF aborts the frame
    repeat (3) @(negedge clk);
    b1.req0_valid = 1'b1; b1.req0_data = 8'hFF;
    @(negedge clk);
    b1.req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("ff_bit4_valid", 32'(mon_valid), 32'd1);
    reset = 1'b1;
    #1;
    check_quiet("abort");
    check("abort_busy", 32'(mon_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_quiet("no_replay");
    end
    b1.req0_valid = 1'b1; b1.req0_data = 8'h11;
    b1.req1_valid = 1'b1; b1.req1_data = 8'h22;
    #1;
    check("post_rst_rdy0", 32'(mon_r0), 32'd1);
    check("post_rst_rdy1", 32'(mon_r1), 32'd0);
    @(negedge clk);
    b1.req0_valid = 1'b0; b1.req1_valid = 1'b0;
    expect_frame("p11", 8'h11, 1'b0);

    // GAP_CYCLES=0: back-to-back words with exactly one IDLE cycle between
    use_b2 = 1'b1;
    @(negedge clk);
    b2.req0_valid = 1'b1; b2.req0_data = 8'h81;
    #1;
    check("ng_rdy0", 32'(mon_r0), 32'd1);
    @(negedge clk);
    b2.req0_data = 8'h7E;
    expect_frame("ng1", 8'h81, 1'b0);
    @(negedge clk);
    check_quiet("ng_idle");
    check("ng_idle_busy", 32'(mon_busy), 32'd0);
    check("ng_idle_rdy0", 32'(mon_r0), 32'd1);
    @(negedge clk);
    b2.req0_valid = 1'b0;
    expect_frame("ng2", 8'h7E, 1'b0);
    @(negedge clk);
    check_quiet("ng_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
